exe_muldiv: RTL and testbench
=============================

Name: exe_muldiv

Overview:
Parametrised iterative multiply/divide unit for the EXE stage of the five-stage pipeline. It replaces the fixed 32-bit multiplier and adds unsigned multiply plus signed and unsigned divide. Results are written to the HI/LO path.
The EXE stage asserts start when EXE_valid is high and the instruction is a mul/div. It holds EXE_over low until done is asserted.

Parameters:
WIDTH, 32, operand width in bits; HI and LO are each WIDTH bits.
CNT_W, 6, iteration counter width; must satisfy 2^CNT_W > WIDTH.

Ports:
clk  in  1  clock
resetn  in  1  asynchronous active-low reset
start  in  1  request; sampled only while busy=0
op  in  2  00 MULT, 01 MULTU, 10 DIV, 11 DIVU; sampled with start
src1  in  WIDTH  multiplicand / dividend
src2  in  WIDTH  multiplier / divisor
cancel  in  1  synchronous abort (exception flush from WB)
busy  out  1  operation in progress
done  out  1  one-cycle pulse; hi/lo valid
hi  out  WIDTH  product upper half / remainder
lo  out  WIDTH  product lower half / quotient
div_zero  out  1  last completed op was DIV/DIVU with src2=0

Behaviour:
- Reset (resetn=0, async): state=IDLE, busy=0, done=0, hi=0, lo=0, div_zero=0, counter=0.
- States:
  - IDLE: start=1 latches op, src1, src2 and moves to CALC. Signed ops latch operand magnitudes and the result signs. Counter is set to WIDTH-1.
  - CALC: one radix-2 step per cycle. Multiply uses shift-add on a 2*WIDTH accumulator. Divide uses a restoring shift-subtract. The counter decrements each step; at 0 the state moves to FIX.
  - FIX: applies the sign corrections, then moves to DONE.
  - DONE: done=1 for one cycle; hi, lo and div_zero are updated; the state returns to IDLE.
- Timing: start accepted at edge t gives busy=1 in cycles t+1..t+WIDTH+1. done=1 with busy=0 in cycle t+WIDTH+2.
- A new start in the done cycle is accepted (back-to-back operation).
- start while busy=1 is ignored.
- hi, lo and div_zero hold their values until the next DONE. They do not change during CALC.
- Signed multiply: the product is negated if the operand signs differ.
- Signed divide truncates toward zero. The quotient is negated if the signs differ; the remainder takes the sign of the dividend.
- Most-negative / -1 (0x80000000/0xFFFFFFFF at WIDTH=32): lo=0x80000000, hi=0, no trap.
- Divide by zero (signed or unsigned): lo=all ones, hi=src1 unchanged, div_zero=1.
- Multiply always clears div_zero.
- cancel=1 in any non-IDLE state: the state goes to IDLE next edge, busy=0, no done, hi/lo/div_zero unchanged.
- cancel in IDLE is ignored, and cancel takes priority over a simultaneous start.
- Reset mid-operation: immediate return to reset values; no done.
- Any WIDTH ≥ 4 gives the same behaviour with latency WIDTH+2.

Optional Feature:
MULDIV_EARLY_OUT_EN.
- Defined: if the op is a multiply with src1=0 or src2=0, or a divide with src2=0, the unit skips CALC and goes IDLE→FIX→DONE. done is asserted in cycle t+2 with the same results as the full path.
- Undefined: every op takes WIDTH+2 cycles.

Test Plan:
- MULT src1=0xFFFFFFFE, src2=0x00000003 → done at t+34, hi=0xFFFFFFFF, lo=0xFFFFFFFA, div_zero=0.
- MULTU src1=src2=0xFFFFFFFF → hi=0xFFFFFFFE, lo=0x00000001. Then start in the done cycle with MULTU 2×3 → hi=0, lo=6 exactly 34 cycles later.
- DIV src1=0xFFFFFFF9 (-7), src2=2 → lo=0xFFFFFFFD, hi=0xFFFFFFFF. DIV 0x80000000/0xFFFFFFFF → lo=0x80000000, hi=0.
- DIVU src1=100, src2=0 → lo=0xFFFFFFFF, hi=0x00000064, div_zero=1. With MULDIV_EARLY_OUT_EN defined, done at t+2.
- Start DIVU 50/7, cancel at t+10 → busy=0 at t+11, no done, hi/lo keep previous values. Next DIVU 50/7 → lo=7, hi=1.
- Start MULT, drop resetn at t+5 asynchronously → busy, done, hi, lo immediately 0. After release, start stays ignored until resetn=1, and the next op completes normally.

Source files
------------

// File: rtl/exe_muldiv.sv
// exe_muldiv: iterative radix-2 multiply/divide unit for the EXE stage.
// It takes WIDTH+2 cycles from start to done and writes its result to the HI/LO path.
//   op 00 MULT (signed), 01 MULTU, 10 DIV (signed), 11 DIVU.
// Ports:
//   clk, resetn         clock, asynchronous active-low reset
//   start, op, src1/2   request, operation and operands (sampled only while not busy)
//   cancel              synchronous abort; drops the operation without producing done
//   busy, done          operation in progress / one-cycle result-valid pulse
//   hi, lo              product upper/lower half, or remainder/quotient
//   div_zero            last completed op was a divide with src2 == 0
// Optional build macro MULDIV_EARLY_OUT_EN: a multiply with a zero operand, or a
// divide by zero, skips CALC and completes with done in cycle t+2.
//
// state  | meaning
// S_IDLE | waiting for start
// S_CALC | one shift-add / shift-subtract step per cycle, cnt_q counts down
// S_FIX  | sign correction, result registered into hi/lo
// S_DONE | done pulse; a new start is accepted here
module exe_muldiv #(
   parameter int WIDTH = 32,
   parameter int CNT_W = 6
) (
   input  logic             clk,
   input  logic             resetn,
   input  logic             start,
   input  logic [1:0]       op,
   input  logic [WIDTH-1:0] src1,
   input  logic [WIDTH-1:0] src2,
   input  logic             cancel,
   output logic             busy,
   output logic             done,
   output logic [WIDTH-1:0] hi,
   output logic [WIDTH-1:0] lo,
   output logic             div_zero
);

   typedef enum logic [1:0] {S_IDLE, S_CALC, S_FIX, S_DONE} state_t;

   state_t               state_q, state_d;
   logic [CNT_W-1:0]     cnt_q, cnt_d;
   logic [2*WIDTH-1:0]   acc_q, acc_d;
   logic [WIDTH-1:0]     b_q, b_d;
   logic                 is_div_q, is_div_d;
   logic                 neg_q, neg_d;
   logic                 rem_neg_q, rem_neg_d;
   logic                 dz_q, dz_d;
   logic [WIDTH-1:0]     hi_q, hi_d;
   logic [WIDTH-1:0]     lo_q, lo_d;
   logic                 div_zero_q, div_zero_d;

   logic                 s1_neg, s2_neg, early;
   logic [WIDTH-1:0]     a_mag, b_mag;
   logic [WIDTH:0]       mul_sum, rem_sh, rem_sub;
   logic [WIDTH-1:0]     new_rem;
   logic                 rem_ge;
   logic [2*WIDTH-1:0]   mul_next, div_next, prod;

   always_comb begin
      // operand magnitudes and result signs for the request on the inputs
      s1_neg = ~op[0] & src1[WIDTH-1];
      s2_neg = ~op[0] & src2[WIDTH-1];
      a_mag  = s1_neg ? -src1 : src1;
      b_mag  = s2_neg ? -src2 : src2;
`ifdef MULDIV_EARLY_OUT_EN
      early  = op[1] ? (src2 == '0) : ((src1 == '0) || (src2 == '0));
`else
      early  = 1'b0;
`endif

      // acc = {partial product, remaining multiplier bits}, LSB-first shift-add
      mul_sum  = {1'b0, acc_q[2*WIDTH-1:WIDTH]} + (acc_q[0] ? {1'b0, b_q} : '0);
      mul_next = {mul_sum, acc_q[WIDTH-1:1]};

      // acc = {remainder, dividend bits / quotient bits}, restoring division;
      // rem < b always holds, so rem_sh fits in WIDTH+1 bits
      rem_sh   = {acc_q[2*WIDTH-1:WIDTH], acc_q[WIDTH-1]};
      rem_ge   = rem_sh >= {1'b0, b_q};
      rem_sub  = rem_sh - {1'b0, b_q};
      new_rem  = rem_ge ? rem_sub[WIDTH-1:0] : rem_sh[WIDTH-1:0];
      div_next = {new_rem, acc_q[WIDTH-2:0], rem_ge};

      prod = neg_q ? -acc_q : acc_q;

      state_d    = state_q;
      cnt_d      = cnt_q;
      acc_d      = acc_q;
      b_d        = b_q;
      is_div_d   = is_div_q;
      neg_d      = neg_q;
      rem_neg_d  = rem_neg_q;
      dz_d       = dz_q;
      hi_d       = hi_q;
      lo_d       = lo_q;
      div_zero_d = div_zero_q;

      case (state_q)
         S_IDLE, S_DONE: begin
            state_d = S_IDLE;
            if (start && !cancel) begin
               is_div_d  = op[1];
               neg_d     = s1_neg ^ s2_neg;
               rem_neg_d = s1_neg;
               dz_d      = op[1] && (src2 == '0);
               b_d       = b_mag;
               cnt_d     = CNT_W'(WIDTH - 1);
               if (early) begin
                  // divide by zero leaves the dividend as remainder; multiply by zero is 0
                  acc_d   = op[1] ? {a_mag, {WIDTH{1'b0}}} : '0;
                  state_d = S_FIX;
               end else begin
                  acc_d   = {{WIDTH{1'b0}}, a_mag};
                  state_d = S_CALC;
               end
            end
         end
         S_CALC: begin
            if (cancel) begin
               state_d = S_IDLE;
            end else begin
               acc_d = is_div_q ? div_next : mul_next;
               cnt_d = cnt_q - 1'b1;
               if (cnt_q == '0) state_d = S_FIX;
            end
         end
         S_FIX: begin
            if (cancel) begin
               state_d = S_IDLE;
            end else begin
               state_d = S_DONE;
               if (is_div_q) begin
                  hi_d       = rem_neg_q ? -acc_q[2*WIDTH-1:WIDTH] : acc_q[2*WIDTH-1:WIDTH];
                  lo_d       = dz_q ? {WIDTH{1'b1}}
                                    : (neg_q ? -acc_q[WIDTH-1:0] : acc_q[WIDTH-1:0]);
                  div_zero_d = dz_q;
               end else begin
                  hi_d       = prod[2*WIDTH-1:WIDTH];
                  lo_d       = prod[WIDTH-1:0];
                  div_zero_d = 1'b0;
               end
            end
         end
         default: state_d = S_IDLE;
      endcase
   end

   always_ff @(posedge clk or negedge resetn) begin
      if (!resetn) begin
         state_q    <= S_IDLE;
         cnt_q      <= '0;
         acc_q      <= '0;
         b_q        <= '0;
         is_div_q   <= 1'b0;
         neg_q      <= 1'b0;
         rem_neg_q  <= 1'b0;
         dz_q       <= 1'b0;
         hi_q       <= '0;
         lo_q       <= '0;
         div_zero_q <= 1'b0;
      end else begin
         state_q    <= state_d;
         cnt_q      <= cnt_d;
         acc_q      <= acc_d;
         b_q        <= b_d;
         is_div_q   <= is_div_d;
         neg_q      <= neg_d;
         rem_neg_q  <= rem_neg_d;
         dz_q       <= dz_d;
         hi_q       <= hi_d;
         lo_q       <= lo_d;
         div_zero_q <= div_zero_d;
      end
   end

   assign busy     = (state_q == S_CALC) || (state_q == S_FIX);
   assign done     = (state_q == S_DONE);
   assign hi       = hi_q;
   assign lo       = lo_q;
   assign div_zero = div_zero_q;

endmodule

// File: tb/tb_exe_muldiv.sv
module tb_exe_muldiv;
   localparam int W = 32;
`ifdef MULDIV_EARLY_OUT_EN
   localparam int LAT_Z = 1;
`else
   localparam int LAT_Z = W + 1;
`endif
   localparam int LAT = W + 1;

   logic         clk = 1'b0;
   logic         resetn, start, cancel;
   logic [1:0]   op;
   logic [W-1:0] src1, src2;
   logic         busy, done, div_zero;
   logic [W-1:0] hi, lo;

   int nvec  = 0;
   int nfail = 0;

   exe_muldiv #(.WIDTH(W), .CNT_W(6)) dut (
      .clk(clk), .resetn(resetn), .start(start), .op(op), .src1(src1), .src2(src2),
      .cancel(cancel), .busy(busy), .done(done), .hi(hi), .lo(lo), .div_zero(div_zero)
   );

   always #5 clk = ~clk;

   task automatic chk(input string tag, input logic [W-1:0] obs, input logic [W-1:0] exp);
      nvec++;
      assert (obs === exp) else begin
         nfail++;
         $error("FAIL %s: observed %h expected %h", tag, obs, exp);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   // Issue one op, then count edges after the accept edge until done (bounded).
   task automatic run_op(input string tag, input logic [1:0] o, input logic [W-1:0] a,
                         input logic [W-1:0] b, input int lat, input logic [W-1:0] ehi,
                         input logic [W-1:0] elo, input logic edz, input bit poke);
      logic [W-1:0] phi, plo;
      int n;
      phi = hi;
      plo = lo;
      op = o; src1 = a; src2 = b; start = 1'b1;
      tick();
      start = 1'b0;
      chk({tag, " busy_t1"}, W'(busy), W'(1));
      n = 0;
      while (!done && n < 200) begin
         tick();
         n++;
         if (poke && n == 5) begin
            start = 1'b1; op = 2'b01; src1 = 32'h1234_5678; src2 = 32'h0000_0010;
         end else if (poke && n == 6) begin
            start = 1'b0;
         end
         if (n == 2 && lat > 2) begin
            chk({tag, " hi_hold"}, hi, phi);
            chk({tag, " lo_hold"}, lo, plo);
         end
      end
      chk({tag, " latency"}, W'(n), W'(lat));
      chk({tag, " busy_done"}, W'(busy), W'(0));
      chk({tag, " hi"}, hi, ehi);
      chk({tag, " lo"}, lo, elo);
      chk({tag, " div_zero"}, W'(div_zero), W'(edz));
   endtask

   initial begin
      int seen;
      resetn = 1'b0; start = 1'b0; cancel = 1'b0; op = 2'b00; src1 = '0; src2 = '0;
      #12;
      chk("rst busy", W'(busy), W'(0));
      chk("rst done", W'(done), W'(0));
      chk("rst hi", hi, '0);
      chk("rst lo", lo, '0);
      chk("rst dz", W'(div_zero), W'(0));
      resetn = 1'b1;
      tick();

      run_op("mult_neg", 2'b00, 32'hFFFF_FFFE, 32'h0000_0003, LAT, 32'hFFFF_FFFF, 32'hFFFF_FFFA, 1'b0, 1'b1);
      tick(); tick();
      run_op("multu_max", 2'b01, 32'hFFFF_FFFF, 32'hFFFF_FFFF, LAT, 32'hFFFF_FFFE, 32'h0000_0001, 1'b0, 1'b0);
      run_op("multu_b2b", 2'b01, 32'h0000_0002, 32'h0000_0003, LAT, 32'h0000_0000, 32'h0000_0006, 1'b0, 1'b0);
      tick(); tick();
      run_op("div_m7_2", 2'b10, 32'hFFFF_FFF9, 32'h0000_0002, LAT, 32'hFFFF_FFFF, 32'hFFFF_FFFD, 1'b0, 1'b0);
      tick();
      run_op("div_ovf", 2'b10, 32'h8000_0000, 32'hFFFF_FFFF, LAT, 32'h0000_0000, 32'h8000_0000, 1'b0, 1'b0);
      tick();
      run_op("div_7_m2", 2'b10, 32'h0000_0007, 32'hFFFF_FFFE, LAT, 32'h0000_0001, 32'hFFFF_FFFD, 1'b0, 1'b0);
      tick();
      run_op("divu_z", 2'b11, 32'h0000_0064, 32'h0000_0000, LAT_Z, 32'h0000_0064, 32'hFFFF_FFFF, 1'b1, 1'b0);
      tick();
      run_op("mult_z", 2'b00, 32'h0000_0000, 32'h0000_0005, LAT_Z, 32'h0000_0000, 32'h0000_0000, 1'b0, 1'b0);
      tick();
      run_op("div_z", 2'b10, 32'hFFFF_FFFB, 32'h0000_0000, LAT_Z, 32'hFFFF_FFFB, 32'hFFFF_FFFF, 1'b1, 1'b0);
      tick();

      // cancel mid-operation
      op = 2'b11; src1 = 32'd50; src2 = 32'd7; start = 1'b1;
      tick();
      start = 1'b0;
      repeat (9) tick();
      cancel = 1'b1;
      tick();
      cancel = 1'b0;
      chk("cancel busy", W'(busy), W'(0));
      seen = 0;
      for (int i = 0; i < 40; i++) begin
         tick();
         if (done) seen++;
      end
      chk("cancel no_done", W'(seen), W'(0));
      chk("cancel hi", hi, 32'hFFFF_FFFB);
      chk("cancel lo", lo, 32'hFFFF_FFFF);
      chk("cancel dz", W'(div_zero), W'(1));
      run_op("divu_50_7", 2'b11, 32'd50, 32'd7, LAT, 32'h0000_0001, 32'h0000_0007, 1'b0, 1'b0);
      tick();

      // asynchronous reset mid-operation
      op = 2'b00; src1 = 32'd3; src2 = 32'd4; start = 1'b1;
      tick();
      start = 1'b0;
      repeat (4) tick();
      #2 resetn = 1'b0;
      #1;
      chk("arst busy", W'(busy), W'(0));
      chk("arst done", W'(done), W'(0));
      chk("arst hi", hi, '0);
      chk("arst lo", lo, '0);
      chk("arst dz", W'(div_zero), W'(0));
      start = 1'b1;
      tick();
      chk("arst start_ign1", W'(busy), W'(0));
      tick();
      chk("arst start_ign2", W'(busy), W'(0));
      start = 1'b0;
      #2 resetn = 1'b1;
      tick();
      chk("arst idle", W'(busy), W'(0));
      run_op("mult_after_rst", 2'b00, 32'd3, 32'd4, LAT, 32'h0000_0000, 32'h0000_000C, 1'b0, 1'b0);

      $display("== %0d vectors applied, %0d miscompares ==", nvec, nfail);
      $finish;
   end
endmodule
